// File: rtl/data_sram_responder_pkg.sv
// Shared definitions for the CPU data SRAM responder: MMIO offsets, defaults,
// read-source select and the byte-lane merge helper.
package data_sram_responder_pkg;

   localparam int          RAM_ADDR_W_DEF = 14;
   localparam logic [31:0] MMIO_BASE_DEF  = 32'hBFAF_0000;
   localparam int          LED_W_DEF      = 16;
   localparam int          SW_W_DEF       = 8;

   localparam logic [15:0] OFF_LED    = 16'h0000;
   localparam logic [15:0] OFF_SWITCH = 16'h0004;
   localparam logic [15:0] OFF_TIMER  = 16'h0008;
   localparam logic [15:0] OFF_NUM    = 16'h000C;

   typedef enum logic {
      SRC_MMIO = 1'b0,
      SRC_RAM  = 1'b1
   } rd_src_e;

   function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  we);
      logic [31:0] r;
      r = old_v;
      for (int i = 0; i < 4; i++)
         if (we[i]) r[8*i +: 8] = wdata[8*i +: 8];
      return r;
   endfunction

endpackage

// File: rtl/data_sram_responder_if.sv
// CPU data SRAM port: request fields driven by the CPU, rdata returned one cycle later.
interface data_sram_responder_if;
   logic        data_sram_en;
   logic [3:0]  data_sram_we;
   logic [31:0] data_sram_addr;
   logic [31:0] data_sram_wdata;
   logic [31:0] data_sram_rdata;

   modport master (output data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
                   input  data_sram_rdata);
   modport slave  (input  data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
                   output data_sram_rdata);
endinterface

// File: rtl/data_sram_responder_sram_bank.sv
// Byte-writable, read-first synchronous RAM, 32-bit words, no reset so it maps onto BRAM.
module sram_bank #(
   parameter int AW = 14
) (
   input  logic          clk_i,
   input  logic          en_i,
   input  logic [3:0]    we_i,
   input  logic [AW-1:0] addr_i,
   input  logic [31:0]   wdata_i,
   output logic [31:0]   rdata_o
);

   logic [31:0] mem_q [0:(1<<AW)-1];

   // Output register holds its value while the bank is not enabled.
   always_ff @(posedge clk_i) begin
      if (en_i) begin
         rdata_o <= mem_q[addr_i];
         for (int i = 0; i < 4; i++)
            if (we_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
   end

endmodule

// File: rtl/data_sram_responder.sv
// Data SRAM slave: decodes RAM vs MMIO window, owns LED/NUM/TIMER registers and the
// switch synchroniser, and returns read data one cycle after the request.
module data_sram_responder
   import data_sram_responder_pkg::*;
#(
   parameter int          RAM_ADDR_W = RAM_ADDR_W_DEF,
   parameter logic [31:0] MMIO_BASE  = MMIO_BASE_DEF,
   parameter int          LED_W      = LED_W_DEF,
   parameter int          SW_W       = SW_W_DEF
) (
   input  logic                 clk,
   input  logic                 resetn,
   data_sram_responder_if.slave bus,
   input  logic [SW_W-1:0]      switch_in,
   output logic [LED_W-1:0]     led_out,
   output logic [31:0]          num_out
);

   logic             mmio_hit, mmio_wr, ram_en;
   logic [15:0]      off;
   logic [31:0]      ram_rdata;
   logic [31:0]      mmio_rd_d, mmio_rd_q;
   logic [31:0]      timer_d, timer_q;
   logic [31:0]      num_q;
   logic [LED_W-1:0] led_q;
   logic [SW_W-1:0]  sw_meta_q, sw_sync_q;
   rd_src_e          src_q;

   assign mmio_hit = bus.data_sram_addr[31:16] == MMIO_BASE[31:16];
   assign off      = bus.data_sram_addr[15:0] & 16'hFFFC;
   assign mmio_wr  = bus.data_sram_en & mmio_hit & (|bus.data_sram_we);
   assign ram_en   = bus.data_sram_en & ~mmio_hit;

   sram_bank #(.AW(RAM_ADDR_W)) u_bank (
      .clk_i   (clk),
      .en_i    (ram_en),
      .we_i    (bus.data_sram_we),
      .addr_i  (bus.data_sram_addr[RAM_ADDR_W+1:2]),
      .wdata_i (bus.data_sram_wdata),
      .rdata_o (ram_rdata)
   );

   always_comb begin
      mmio_rd_d = '0;
      case (off)
         OFF_LED:    mmio_rd_d = 32'(led_q);
         OFF_SWITCH: mmio_rd_d = 32'(sw_sync_q);
         OFF_TIMER:  mmio_rd_d = timer_q;
         OFF_NUM:    mmio_rd_d = num_q;
         default:    mmio_rd_d = '0;
      endcase
   end

   // A timer write replaces that cycle's increment.
   assign timer_d = (mmio_wr && off == OFF_TIMER)
                    ? byte_merge(timer_q, bus.data_sram_wdata, bus.data_sram_we)
                    : timer_q + 32'd1;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         src_q     <= SRC_MMIO;
         mmio_rd_q <= '0;
         timer_q   <= '0;
         led_q     <= '0;
         num_q     <= '0;
         sw_meta_q <= '0;
         sw_sync_q <= '0;
      end else begin
         timer_q   <= timer_d;
         sw_meta_q <= switch_in;
         sw_sync_q <= sw_meta_q;
         if (bus.data_sram_en) begin
            src_q <= mmio_hit ? SRC_MMIO : SRC_RAM;
            if (mmio_hit) mmio_rd_q <= mmio_rd_d;
         end
         if (mmio_wr && off == OFF_LED)
            led_q <= LED_W'(byte_merge(32'(led_q), bus.data_sram_wdata, bus.data_sram_we));
         if (mmio_wr && off == OFF_NUM)
            num_q <= byte_merge(num_q, bus.data_sram_wdata, bus.data_sram_we);
      end
   end

   // Reset parks the select on the cleared MMIO register, so rdata drops to 0 at once.
   assign bus.data_sram_rdata = (src_q == SRC_RAM) ? ram_rdata : mmio_rd_q;
   assign led_out = led_q;
   assign num_out = num_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: directed literal cases plus a randomized run checked
// every cycle against a word/register-level model of the memory map.
module tb_data_sram_responder;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic [7:0]  switch_in = 8'h00;
   logic [15:0] led_out;
   logic [31:0] num_out;
   int          n_chk = 0;
   int          n_pass = 0;

   data_sram_responder_if bus ();

   data_sram_responder dut (
      .clk       (clk),
      .resetn    (resetn),
      .bus       (bus),
      .switch_in (switch_in),
      .led_out   (led_out),
      .num_out   (num_out)
   );

   always #5 clk = ~clk;

   localparam logic [31:0] A_LED = 32'hBFAF_0000;
   localparam logic [31:0] A_SW  = 32'hBFAF_0004;
   localparam logic [31:0] A_TMR = 32'hBFAF_0008;
   localparam logic [31:0] A_NUM = 32'hBFAF_000C;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] w,
                                         input logic [3:0] we);
      logic [31:0] r;
      r = o;
      for (int i = 0; i < 4; i++) if (we[i]) r[8*i +: 8] = w[8*i +: 8];
      return r;
   endfunction

   // Reference model: state as the memory map describes it, updated once per edge.
   logic [31:0] m_mem [int];
   logic [3:0]  m_kn  [int];
   logic [31:0] m_rdata, m_timer, m_num;
   logic [15:0] m_led;
   logic [7:0]  m_meta, m_sync;
   logic        m_known;

   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         m_rdata = 0; m_known = 1'b1; m_timer = 0; m_num = 0; m_led = 0;
         m_meta = 0; m_sync = 0;
      end else begin
         logic        en, hit, wr;
         logic [3:0]  we, kn;
         logic [31:0] a, w, old;
         logic [15:0] off;
         logic [31:0] tmp;
         int          idx;
         en  = bus.data_sram_en; we = bus.data_sram_we;
         a   = bus.data_sram_addr; w = bus.data_sram_wdata;
         hit = (a[31:16] == 16'hBFAF);
         off = {a[15:2], 2'b00};
         idx = int'(a[15:2]);
         wr  = en && hit && (we != 0);
         if (en && hit) begin
            case (off)
               16'h0000: m_rdata = {16'h0, m_led};
               16'h0004: m_rdata = {24'h0, m_sync};
               16'h0008: m_rdata = m_timer;
               16'h000C: m_rdata = m_num;
               default:  m_rdata = 0;
            endcase
            m_known = 1'b1;
         end else if (en) begin
            kn  = m_kn.exists(idx) ? m_kn[idx] : 4'h0;
            old = m_mem.exists(idx) ? m_mem[idx] : 32'h0;
            m_known = (kn == 4'hF);
            m_rdata = old;
            if (we != 0) begin
               m_mem[idx] = merge(old, w, we);
               m_kn[idx]  = kn | we;
            end
         end
         m_timer = (wr && off == 16'h0008) ? merge(m_timer, w, we) : m_timer + 1;
         if (wr && off == 16'h0000) begin
            tmp = merge({16'h0, m_led}, w, we);
            m_led = tmp[15:0];
         end
         if (wr && off == 16'h000C) m_num = merge(m_num, w, we);
         m_sync = m_meta;
         m_meta = switch_in;
      end
   end

   always @(negedge clk) begin
      if (resetn === 1'b1) begin
         if (m_known) check("rdata", bus.data_sram_rdata, m_rdata);
         check("led_out", {16'h0, led_out}, {16'h0, m_led});
         check("num_out", num_out, m_num);
      end
   end

   task automatic op(input logic en, input logic [3:0] we, input logic [31:0] a,
                     input logic [31:0] d);
      @(negedge clk);
      bus.data_sram_en = en; bus.data_sram_we = we;
      bus.data_sram_addr = a; bus.data_sram_wdata = d;
   endtask

   task automatic idle();
      op(1'b0, 4'h0, 32'h0, 32'h0);
   endtask

   initial begin
      logic [31:0] up;
      bus.data_sram_en = 0; bus.data_sram_we = 0;
      bus.data_sram_addr = 0; bus.data_sram_wdata = 0;
      repeat (3) @(negedge clk);
      check("reset rdata", bus.data_sram_rdata, 32'h0);
      check("reset led", {16'h0, led_out}, 32'h0);
      check("reset num", num_out, 32'h0);
      resetn = 1'b1;

      // 1: full write then read
      op(1, 4'hF, 32'h1C00_0100, 32'h1234_5678);
      op(1, 4'h0, 32'h1C00_0100, 32'h0);
      idle();                                   check("t1 read", bus.data_sram_rdata, 32'h1234_5678);
      // 2: single-lane write, read-first data
      op(1, 4'b0010, 32'h1C00_0100, 32'hAABB_CCDD);
      op(1, 4'h0, 32'h1C00_0100, 32'h0);        check("t2 wr rdata", bus.data_sram_rdata, 32'h1234_5678);
      idle();                                   check("t2 read", bus.data_sram_rdata, 32'h1234_CC78);
      // 3: timer wrap
      op(1, 4'hF, A_TMR, 32'hFFFF_FFFE);
      idle(); idle();
      op(1, 4'h0, A_TMR, 32'h0);
      op(1, 4'h0, A_TMR, 32'h0);                check("t3 wrap", bus.data_sram_rdata, 32'h0);
      idle();                                   check("t3 next", bus.data_sram_rdata, 32'h1);
      // 4: switch synchroniser, write ignored
      switch_in = 8'hA5;
      idle();
      op(1, 4'h0, A_SW, 32'h0);
      op(1, 4'hF, A_SW, 32'hFFFF_FFFF);         check("t4 switch", bus.data_sram_rdata, 32'hA5);
      op(1, 4'h0, A_SW, 32'h0);
      idle();                                   check("t4 sw after wr", bus.data_sram_rdata, 32'hA5);
      // 5: LED width and unmapped offset
      op(1, 4'hF, A_LED, 32'hFFFF_FFFF);
      op(1, 4'h0, A_LED, 32'h0);                check("t5 led_out", {16'h0, led_out}, 32'h0000_FFFF);
      op(1, 4'h0, 32'hBFAF_0020, 32'h0);        check("t5 led read", bus.data_sram_rdata, 32'h0000_FFFF);
      idle();                                   check("t5 unmapped", bus.data_sram_rdata, 32'h0);
      // 6: async reset mid-read, RAM retained
      op(1, 4'hF, 32'h1C00_0200, 32'hCAFE_F00D);
      op(1, 4'hF, A_NUM, 32'h00C0_FFEE);
      op(1, 4'h0, 32'h1C00_0200, 32'h0);
      op(1, 4'h0, 32'h1C00_0100, 32'h0);        check("t6 num_out", num_out, 32'h00C0_FFEE);
      check("t6 pre-rst rdata", bus.data_sram_rdata, 32'hCAFE_F00D);
      #2 resetn = 1'b0;
      #1;
      check("t6 rst rdata", bus.data_sram_rdata, 32'h0);
      check("t6 rst led", {16'h0, led_out}, 32'h0);
      check("t6 rst num", num_out, 32'h0);
      bus.data_sram_en = 0;
      @(negedge clk);
      @(negedge clk); resetn = 1'b1;
      op(1, 4'h0, 32'h1C00_0100, 32'h0);
      op(1, 4'h0, 32'h1C00_0200, 32'h0);        check("t6 ram kept a", bus.data_sram_rdata, 32'h1234_CC78);
      idle();                                   check("t6 ram kept b", bus.data_sram_rdata, 32'hCAFE_F00D);

      // Randomized traffic; the per-cycle compare process does the checking.
      repeat (600) begin
         logic [31:0] a;
         logic [3:0]  we;
         logic [15:0] offs [7];
         offs = '{16'h0000, 16'h0004, 16'h0008, 16'h000C, 16'h0010, 16'h0020, 16'hFFFC};
         up = $urandom;
         if (up[31:16] == 16'hBFAF) up[31:16] = 16'h1C00;
         we = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
         if ($urandom_range(0, 2) == 2) a = {16'hBFAF, offs[$urandom_range(0, 6)]};
         else a = {up[31:16], 14'(14'h40 + $urandom_range(0, 15)), up[1:0]};
         if ($urandom_range(0, 9) == 0) switch_in = 8'($urandom);
         op($urandom_range(0, 9) < 8, we, a, $urandom);
      end
      idle(); idle();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
